// File: rtl/window_gen.sv
// window_gen: streaming zero-padded 3x3 neighbourhood generator for column-major pixel input.
// A 2*DEPTH+2 deep delay line feeds fixed taps; edge masks blank taps that wrap across columns.
module window_gen #(
   parameter int WIDTH = 361,
   parameter int DEPTH = 410,
   parameter int SIZE  = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [SIZE-1:0] in_data,
   output logic            in_ready,
   output logic            out_valid,
   output logic [SIZE-1:0] n0,
   output logic [SIZE-1:0] n1,
   output logic [SIZE-1:0] n2,
   output logic [SIZE-1:0] n3,
   output logic [SIZE-1:0] n4,
   output logic [SIZE-1:0] n5,
   output logic [SIZE-1:0] n6,
   output logic [SIZE-1:0] n7,
   output logic [SIZE-1:0] n8,
   output logic [15:0]     out_col,
   output logic [15:0]     out_row,
   output logic            done
);
   localparam int              TAPS       = 2*DEPTH + 2;
   localparam logic [15:0]     LAST_COL   = 16'(WIDTH - 1);
   localparam logic [15:0]     LAST_ROW   = 16'(DEPTH - 1);
   localparam logic [15:0]     FLUSH_LAST = 16'(DEPTH);
   localparam logic [SIZE-1:0] PIX_ZERO   = {SIZE{1'b0}};

   typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic                   done_q, done_d;
   logic [15:0]            col_q, col_d, row_q, row_d;
   logic [15:0]            cc_q, cc_d, rr_q, rr_d;
   logic [15:0]            flush_q, flush_d;
   logic [15:0]            out_col_q, out_col_d, out_row_q, out_row_d;
   logic [8:0][SIZE-1:0]   win_q, win_d, win_s;
   logic [SIZE-1:0]        dl_q [TAPS];
   logic [SIZE-1:0]        head_s;
   logic                   xfer_s, emit_s, shift_s;
   logic                   top_s, bot_s, left_s, right_s;

   assign xfer_s = in_valid && in_ready_q;
   assign head_s = (state_q == S_FLUSH) ? PIX_ZERO : in_data;

   // Delay line: dl_q[i] holds the pixel accepted i+1 shifts ago; never observed before it is filled
   always_ff @(posedge clk) begin
      if (shift_s) begin
         dl_q[0] <= head_s;
         for (int i = 1; i < TAPS; i++) begin
            dl_q[i] <= dl_q[i-1];
         end
      end
   end

   // Window gather around the output centre with zero padding at the image border
   always_comb begin
      top_s    = (rr_q == 16'd0);
      bot_s    = (rr_q == LAST_ROW);
      left_s   = (cc_q == 16'd0);
      right_s  = (cc_q == LAST_COL);
      win_s[0] = dl_q[DEPTH];
      win_s[1] = (top_s || left_s)  ? PIX_ZERO : dl_q[2*DEPTH+1];
      win_s[2] = top_s              ? PIX_ZERO : dl_q[DEPTH+1];
      win_s[3] = (top_s || right_s) ? PIX_ZERO : dl_q[1];
      win_s[4] = left_s             ? PIX_ZERO : dl_q[2*DEPTH];
      win_s[5] = right_s            ? PIX_ZERO : dl_q[0];
      win_s[6] = (bot_s || left_s)  ? PIX_ZERO : dl_q[2*DEPTH-1];
      win_s[7] = bot_s              ? PIX_ZERO : dl_q[DEPTH-1];
      win_s[8] = (bot_s || right_s) ? PIX_ZERO : head_s;
   end

   // Next-state: sequencing, input/output counters and registered window outputs
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      cc_d        = cc_q;
      rr_d        = rr_q;
      flush_d     = flush_q;
      win_d       = win_q;
      out_col_d   = out_col_q;
      out_row_d   = out_row_q;
      out_valid_d = 1'b0;
      emit_s      = 1'b0;
      case (state_q)
         S_FILL: begin
            if (xfer_s && (col_q == 16'd1) && (row_q == 16'd0)) begin
               state_d = S_RUN;
            end else begin
               state_d = S_FILL;
            end
         end
         S_RUN: begin
            emit_s = xfer_s;
            if (xfer_s && (col_q == LAST_COL) && (row_q == LAST_ROW)) begin
               state_d = S_FLUSH;
            end else begin
               state_d = S_RUN;
            end
         end
         S_FLUSH: begin
            emit_s = 1'b1;
            if (flush_q == FLUSH_LAST) begin
               state_d = S_DONE;
               flush_d = 16'd0;
            end else begin
               flush_d = flush_q + 16'd1;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
      shift_s = xfer_s || (state_q == S_FLUSH);
      if (xfer_s) begin
         if (row_q == LAST_ROW) begin
            row_d = 16'd0;
            col_d = col_q + 16'd1;
         end else begin
            row_d = row_q + 16'd1;
         end
      end else begin
         row_d = row_q;
      end
      if (emit_s) begin
         out_valid_d = 1'b1;
         win_d       = win_s;
         out_col_d   = cc_q;
         out_row_d   = rr_q;
         if (rr_q == LAST_ROW) begin
            rr_d = 16'd0;
            cc_d = cc_q + 16'd1;
         end else begin
            rr_d = rr_q + 16'd1;
         end
      end else begin
         out_valid_d = 1'b0;
      end
      in_ready_d = (state_d == S_FILL) || (state_d == S_RUN);
      done_d     = (state_q == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FILL;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         col_q       <= 16'd0;
         row_q       <= 16'd0;
         cc_q        <= 16'd0;
         rr_q        <= 16'd0;
         flush_q     <= 16'd0;
         out_col_q   <= 16'd0;
         out_row_q   <= 16'd0;
         win_q       <= {(9*SIZE){1'b0}};
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         col_q       <= col_d;
         row_q       <= row_d;
         cc_q        <= cc_d;
         rr_q        <= rr_d;
         flush_q     <= flush_d;
         out_col_q   <= out_col_d;
         out_row_q   <= out_row_d;
         win_q       <= win_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign out_col   = out_col_q;
   assign out_row   = out_row_q;
   assign n0        = win_q[0];
   assign n1        = win_q[1];
   assign n2        = win_q[2];
   assign n3        = win_q[3];
   assign n4        = win_q[4];
   assign n5        = win_q[5];
   assign n6        = win_q[6];
   assign n7        = win_q[7];
   assign n8        = win_q[8];
endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen on a 4x3 image: a 2-D zero-padded gather model fills a scoreboard
// queue as pixels are accepted; emitted windows are popped and compared.
module tb_window_gen;
   localparam int W = 4;
   localparam int D = 3;
   localparam int N = W * D;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready, out_valid, done;
   logic [7:0]  n0, n1, n2, n3, n4, n5, n6, n7, n8;
   logic [15:0] out_col, out_row;

   typedef struct packed {
      logic [15:0]     col;
      logic [15:0]     row;
      logic [8:0][7:0] n;
   } win_t;

   win_t       exp_q[$];
   win_t       obs[N];
   logic [7:0] img[N];
   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;
   int         first_val = -1;

   window_gen #(.WIDTH(W), .DEPTH(D), .SIZE(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .n0(n0), .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5), .n6(n6),
      .n7(n7), .n8(n8), .out_col(out_col), .out_row(out_row), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pix(int c, int r);
      if (c < 0 || c >= W || r < 0 || r >= D) return 8'd0;
      else return img[c*D + r];
   endfunction

   function automatic win_t gather(int j);
      win_t w;
      int c = j / D;
      int r = j % D;
      w.col  = 16'(c);
      w.row  = 16'(r);
      w.n[0] = pix(c, r);
      w.n[1] = pix(c-1, r-1);
      w.n[2] = pix(c, r-1);
      w.n[3] = pix(c+1, r-1);
      w.n[4] = pix(c-1, r);
      w.n[5] = pix(c+1, r);
      w.n[6] = pix(c-1, r+1);
      w.n[7] = pix(c, r+1);
      w.n[8] = pix(c+1, r+1);
      return w;
   endfunction

   function automatic win_t mkwin(int c, int r, int a0, int a1, int a2, int a3, int a4,
                                  int a5, int a6, int a7, int a8);
      win_t w;
      w.col = 16'(c);  w.row = 16'(r);
      w.n[0] = 8'(a0); w.n[1] = 8'(a1); w.n[2] = 8'(a2);
      w.n[3] = 8'(a3); w.n[4] = 8'(a4); w.n[5] = 8'(a5);
      w.n[6] = 8'(a6); w.n[7] = 8'(a7); w.n[8] = 8'(a8);
      return w;
   endfunction

   task automatic load_ramp();
      for (int i = 0; i < N; i++) img[i] = 8'(i + 1);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
   endtask

   // Drives up to max_x pixels (every other cycle when stall=1) and scores every cycle.
   task automatic run_stream(input bit stall, input int max_x);
      int   k = 0;
      int   cyc = 0;
      int   kb;
      int   flush_left = 0;
      bit   v, rdy, acc, exp_ov;
      bit   done_next = 1'b0;
      bit   exp_done = 1'b0;
      bit   last_seen = 1'b0;
      win_t got, exp_w;
      pulses    = 0;
      first_val = -1;
      while (1) begin
         v        = (k < max_x) && (!stall || (cyc % 2 == 0));
         in_valid = v;
         in_data  = v ? img[k] : 8'($urandom);
         rdy      = in_ready;
         @(posedge clk);
         #1;
         kb       = k;
         acc      = v && rdy;
         exp_ov   = 1'b0;
         exp_done = done_next;
         if (flush_left > 0) begin
            exp_ov = 1'b1;
            flush_left--;
            if (flush_left == 0) done_next = 1'b1;
         end
         if (acc) begin
            k++;
            if (kb > D) begin
               exp_ov = 1'b1;
               exp_q.push_back(gather(kb - D - 1));
            end
            if (k == N) begin
               for (int j = N - D - 1; j < N; j++) exp_q.push_back(gather(j));
               flush_left = D + 1;
               last_seen  = 1'b1;
            end
         end
         checks++;
         if (out_valid !== exp_ov) begin
            errors++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_ov);
         end
         checks++;
         if (done !== exp_done) begin
            errors++;
            $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done);
         end
         if (last_seen) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL in_ready_low cyc=%0d got=%b exp=0", cyc, in_ready);
            end
         end
         if (out_valid === 1'b1) begin
            got.col = out_col; got.row = out_row;
            got.n[0] = n0; got.n[1] = n1; got.n[2] = n2; got.n[3] = n3; got.n[4] = n4;
            got.n[5] = n5; got.n[6] = n6; got.n[7] = n7; got.n[8] = n8;
            if (pulses == 0) first_val = acc ? int'(img[kb]) : -1;
            if (pulses < N) obs[pulses] = got;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL window_unexpected got=%h exp=none", got);
            end else begin
               exp_w = exp_q.pop_front();
               if (got !== exp_w) begin
                  errors++;
                  $display("FAIL window got=%h exp=%h", got, exp_w);
               end
            end
         end
         cyc++;
         if (exp_done) break;
         if (max_x < N && k == max_x) break;
         if (cyc > 300) begin
            checks++;
            errors++;
            $display("FAIL timeout got=%0d cycles exp=done", cyc);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      reset    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, done, out_col, out_row, n0, n1, n2, n3, n4, n5, n6, n7, n8} !== 107'd0) begin
         errors++;
         $display("FAIL reset_values got rdy=%b ov=%b done=%b col=%0d row=%0d n0=%0d exp all 0",
                  in_ready, out_valid, done, out_col, out_row, n0);
      end
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_rise got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_first_window();
      win_t e;
      load_ramp();
      do_reset();
      run_stream(1'b0, N);
      e = mkwin(0, 0, 1, 0, 0, 0, 0, 4, 0, 2, 5);
      checks++;
      if (first_val != 5) begin
         errors++;
         $display("FAIL first_emit_pixel got=%0d exp=5", first_val);
      end
      checks++;
      if (obs[0] !== e) begin
         errors++;
         $display("FAIL first_window got=%h exp=%h", obs[0], e);
      end
   endtask

   task automatic test_interior();
      win_t e;
      load_ramp();
      do_reset();
      run_stream(1'b0, N);
      e = mkwin(1, 1, 5, 1, 4, 7, 2, 8, 3, 6, 9);
      checks++;
      if (obs[4] !== e) begin
         errors++;
         $display("FAIL interior_window got=%h exp=%h", obs[4], e);
      end
   endtask

   task automatic test_flush_done();
      win_t e;
      load_ramp();
      do_reset();
      run_stream(1'b0, N);
      e = mkwin(3, 2, 12, 8, 11, 0, 9, 0, 0, 0, 0);
      checks++;
      if (obs[N-1] !== e) begin
         errors++;
         $display("FAIL last_window got=%h exp=%h", obs[N-1], e);
      end
      checks++;
      if (pulses != N || exp_q.size() != 0) begin
         errors++;
         $display("FAIL pulse_count got=%0d left=%0d exp=%0d left=0", pulses, exp_q.size(), N);
      end
   endtask

   task automatic test_stall();
      win_t e;
      load_ramp();
      do_reset();
      run_stream(1'b1, N);
      e = mkwin(1, 1, 5, 1, 4, 7, 2, 8, 3, 6, 9);
      checks++;
      if (pulses != N || obs[4] !== e) begin
         errors++;
         $display("FAIL stall_stream got pulses=%0d win=%h exp pulses=%0d win=%h", pulses, obs[4], N, e);
      end
   endtask

   task automatic test_reset_mid();
      win_t e;
      load_ramp();
      do_reset();
      run_stream(1'b0, 7);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, done, out_col, out_row, n0, n7} !== 35'd0) begin
         errors++;
         $display("FAIL reset_mid got rdy=%b ov=%b done=%b row=%0d n0=%0d exp all 0",
                  in_ready, out_valid, done, out_row, n0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      run_stream(1'b0, N);
      e = mkwin(0, 0, 1, 0, 0, 0, 0, 4, 0, 2, 5);
      checks++;
      if (pulses != N || obs[0] !== e) begin
         errors++;
         $display("FAIL restream got pulses=%0d win=%h exp pulses=%0d win=%h", pulses, obs[0], N, e);
      end
   endtask

   task automatic test_random_image();
      for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(1, 255));
      do_reset();
      run_stream(1'b0, N);
      checks++;
      if (pulses != N || exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_count got=%0d left=%0d exp=%0d left=0", pulses, exp_q.size(), N);
      end
   endtask

   initial begin
      test_reset();
      test_first_window();
      test_interior();
      test_flush_done();
      test_stall();
      test_reset_mid();
      test_random_image();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
